// File: rtl/heap_feeder.sv
// Input-side sequencer for the top-K heap: packs keypoints into heap words and drives init/en/flush per frame.
// Optional score threshold compiled in with `define HEAP_FEED_THRESH_EN.
module heap_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH  = 16,
  parameter int NLEVELS    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              frame_start,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [KEY_WIDTH-1:0]              s_key,
  input  logic [DATA_WIDTH-2-KEY_WIDTH-1:0] s_payload,
  input  logic                              s_last,
  input  logic [KEY_WIDTH-1:0]              min_key,
  output logic [DATA_WIDTH-1:0]             heap_din,
  output logic                              heap_en,
  output logic                              heap_init,
  output logic                              heap_flush,
  output logic                              busy,
  output logic                              frame_done,
  output logic                              frame_err,
  output logic [CNT_WIDTH-1:0]              pts_in,
  output logic [CNT_WIDTH-1:0]              pts_drop
);
  localparam int DRAIN_CYCLES = (1 << (NLEVELS + 1)) + 3;
  localparam int DCW          = $clog2(DRAIN_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_FLUSH, S_DRAIN} state_t;

  state_t                  r_state, w_next;
  logic [DCW-1:0]          r_drain;
  logic [DATA_WIDTH-1:0]   r_heap_din;
  logic                    r_heap_en;
  logic                    r_frame_err;
  logic [CNT_WIDTH-1:0]    r_pts_in;
  logic                    w_hs, w_drop, w_fwd, w_open;

  assign w_hs   = s_valid & s_ready;
  assign w_fwd  = w_hs & ~w_drop;
  assign w_open = (r_state == S_IDLE) & frame_start;

`ifdef HEAP_FEED_THRESH_EN
  logic [CNT_WIDTH-1:0] r_pts_drop;
  assign w_drop   = (s_key < min_key);
  assign pts_drop = r_pts_drop;

  always_ff @(posedge clk) begin
    if (!rstn)                               r_pts_drop <= '0;
    else if (w_open)                         r_pts_drop <= '0;
    else if (w_hs && w_drop && r_pts_drop != '1) r_pts_drop <= r_pts_drop + CNT_WIDTH'(1);
  end
`else
  logic w_unused;
  assign w_drop   = 1'b0;
  assign w_unused = ^min_key;
  assign pts_drop = '0;
`endif

  always_comb begin
    w_next     = r_state;
    s_ready    = 1'b0;
    heap_init  = 1'b0;
    heap_flush = 1'b0;
    frame_done = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (frame_start) w_next = S_INIT;
      S_INIT:  begin heap_init = 1'b1; w_next = S_RUN; end
      S_RUN:   begin
        s_ready = 1'b1;
        if (s_valid && s_last) w_next = S_FLUSH;
      end
      S_FLUSH: begin heap_flush = 1'b1; w_next = S_DRAIN; end
      S_DRAIN: if (r_drain == '0) begin frame_done = 1'b1; w_next = S_IDLE; end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_drain     <= '0;
      r_heap_din  <= '0;
      r_heap_en   <= 1'b0;
      r_frame_err <= 1'b0;
      r_pts_in    <= '0;
    end else begin
      r_state     <= w_next;
      r_heap_en   <= w_fwd;
      r_frame_err <= frame_start & (r_state != S_IDLE);
      if (w_fwd) r_heap_din <= {2'b00, s_payload, s_key};
      // drain window is counted down to 0 inclusive, so load one less than its length
      if (r_state == S_FLUSH)                   r_drain <= DCW'(DRAIN_CYCLES - 1);
      else if (r_state == S_DRAIN && r_drain != '0) r_drain <= r_drain - DCW'(1);
      if (w_open)                          r_pts_in <= '0;
      else if (w_hs && r_pts_in != '1)     r_pts_in <= r_pts_in + CNT_WIDTH'(1);
    end
  end

  assign heap_din  = r_heap_din;
  assign heap_en   = r_heap_en;
  assign frame_err = r_frame_err;
  assign pts_in    = r_pts_in;
endmodule

// File: tb/tb_heap_feeder.sv
// Directed bench for heap_feeder (NLEVELS=4, CNT_WIDTH=4 so saturation is reachable).
module tb_heap_feeder;
  localparam int DW = 32, KW = 16, PW = DW - 2 - KW;

  logic          clk = 0, rstn = 0, frame_start = 0, s_valid = 0, s_last = 0;
  logic [KW-1:0] s_key = '0, min_key = '0;
  logic [PW-1:0] s_payload = '0;
  logic          s_ready, heap_en, heap_init, heap_flush, busy, frame_done, frame_err;
  logic [DW-1:0] heap_din;
  logic [3:0]    pts_in, pts_drop;

  int n_chk = 0, n_fail = 0, cyc = 0, t_flush = 0;

  heap_feeder #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .NLEVELS(4), .CNT_WIDTH(4)) dut (
    .clk(clk), .rstn(rstn), .frame_start(frame_start), .s_valid(s_valid), .s_ready(s_ready),
    .s_key(s_key), .s_payload(s_payload), .s_last(s_last), .min_key(min_key),
    .heap_din(heap_din), .heap_en(heap_en), .heap_init(heap_init), .heap_flush(heap_flush),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
    .pts_in(pts_in), .pts_drop(pts_drop));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack(input int k);
    logic [PW-1:0] p;
    logic [KW-1:0] kk;
    p  = PW'(k + 100);
    kk = KW'(k);
    return {2'b00, p, kk};
  endfunction

  // beat presented now is sampled at the next edge; caller checks the cycle after
  task automatic beat(input int k, input logic last);
    s_valid = 1; s_key = KW'(k); s_payload = PW'(k + 100); s_last = last;
    step();
  endtask

  // steps until frame_done (bounded); checks cycles since the flush cycle
  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!frame_done && n < 80) begin step(); n++; end
    chk(tag, 32'(cyc - t_flush), 32'd35);
    step();
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_rdy"},  {31'd0, s_ready}, 0);
    chk({tag, "_en"},   {31'd0, heap_en}, 0);
    chk({tag, "_init"}, {31'd0, heap_init}, 0);
    chk({tag, "_fl"},   {31'd0, heap_flush}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, frame_done}, 0);
    chk({tag, "_err"},  {31'd0, frame_err}, 0);
    chk({tag, "_din"},  heap_din, 0);
    chk({tag, "_pin"},  32'(pts_in), 0);
    chk({tag, "_pdr"},  32'(pts_drop), 0);
  endtask

  initial begin
    // reset
    step(); step();
    all_zero("rst");
    rstn = 1; step();

    // frame 1: keys 10..50 back to back
    frame_start = 1; step(); frame_start = 0;
    chk("f1_init", {31'd0, heap_init}, 1);
    chk("f1_busy", {31'd0, busy}, 1);
    chk("f1_rdy_init", {31'd0, s_ready}, 0);
    step();
    chk("f1_rdy_run", {31'd0, s_ready}, 1);
    chk("f1_init_off", {31'd0, heap_init}, 0);
    for (int i = 1; i <= 5; i++) begin
      beat(10 * i, i == 5);
      chk("f1_en", {31'd0, heap_en}, 1);
      chk("f1_din", heap_din, pack(10 * i));
      chk("f1_flag", {30'd0, heap_din[DW-1:DW-2]}, 0);
      chk("f1_flush", {31'd0, heap_flush}, (i == 5) ? 1 : 0);
      chk("f1_rdy", {31'd0, s_ready}, (i == 5) ? 0 : 1);
    end
    t_flush = cyc;
    s_valid = 0; s_last = 0;
    step();
    chk("f1_drain_rdy", {31'd0, s_ready}, 0);
    chk("f1_drain_en", {31'd0, heap_en}, 0);
    chk("f1_pin", 32'(pts_in), 5);
    wait_done("f1_done");
    chk("f1_pin_hold", 32'(pts_in), 5);
    chk("f1_pdr", 32'(pts_drop), 0);

    // frame 2: valid held through INIT, gaps, valid held through FLUSH/DRAIN, stray frame_start
    frame_start = 1; s_valid = 1; s_key = 7; s_payload = PW'(107); step(); frame_start = 0;
    chk("f2_init", {31'd0, heap_init}, 1);
    chk("f2_rdy_init", {31'd0, s_ready}, 0);
    step();
    chk("f2_no_en_init", {31'd0, heap_en}, 0);
    beat(7, 0);
    chk("f2_en7", {31'd0, heap_en}, 1);
    chk("f2_din7", heap_din, pack(7));
    s_valid = 0; s_key = 99; step();
    chk("f2_gap_en", {31'd0, heap_en}, 0);
    chk("f2_gap_din", heap_din, pack(7));
    beat(8, 1);
    t_flush = cyc;
    chk("f2_en8", {31'd0, heap_en}, 1);
    chk("f2_flush", {31'd0, heap_flush}, 1);
    step();
    chk("f2_drain_rdy", {31'd0, s_ready}, 0);
    chk("f2_drain_en", {31'd0, heap_en}, 0);
    step(); step();
    frame_start = 1; step(); frame_start = 0;
    chk("f2_err", {31'd0, frame_err}, 1);
    chk("f2_err_init", {31'd0, heap_init}, 0);
    chk("f2_err_busy", {31'd0, busy}, 1);
    step();
    chk("f2_err_pulse", {31'd0, frame_err}, 0);
    chk("f2_en_off", {31'd0, heap_en}, 0);
    s_valid = 0; s_last = 0;
    wait_done("f2_done");
    chk("f2_pin", 32'(pts_in), 2);

    // reset mid-RUN after 3 beats
    frame_start = 1; step(); frame_start = 0; step();
    for (int i = 1; i <= 3; i++) beat(i, 0);
    chk("r_pin3", 32'(pts_in), 3);
    s_valid = 0; rstn = 0; step();
    all_zero("rmid");
    rstn = 1; frame_start = 1; step(); frame_start = 0;
    chk("r_init", {31'd0, heap_init}, 1);

    // saturation: 20 beats into a 4-bit counter
    step();
    for (int i = 1; i <= 20; i++) beat(i, i == 20);
    t_flush = cyc;
    s_valid = 0; s_last = 0;
    chk("sat_pin", 32'(pts_in), 15);
    chk("sat_din", heap_din, pack(20));
    wait_done("sat_done");
    chk("sat_hold", 32'(pts_in), 15);

`ifdef HEAP_FEED_THRESH_EN
    min_key = 25;
    frame_start = 1; step(); frame_start = 0; step();
    beat(10, 0); chk("th_en10", {31'd0, heap_en}, 0);
    beat(30, 0); chk("th_en30", {31'd0, heap_en}, 1); chk("th_din30", heap_din, pack(30));
    beat(20, 0); chk("th_en20", {31'd0, heap_en}, 0); chk("th_hold", heap_din, pack(30));
    beat(40, 1); chk("th_en40", {31'd0, heap_en}, 1); chk("th_din40", heap_din, pack(40));
    t_flush = cyc;
    s_valid = 0; s_last = 0;
    chk("th_pin", 32'(pts_in), 4);
    chk("th_pdr", 32'(pts_drop), 2);
    wait_done("th_done");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
